// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified code/data memory port arbiter.
package mem_port_arbiter_pkg;

    // FSM state encoding, also exported on the mArbState monitor port
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arbState_t;

    // Grant encoding: which requester owns the current access
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Instruction fetches always read the full word
    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_arb_select.sv
// Priority decision between fetch and data requesters with a starvation guard.
// Data normally wins; after STARVE_LIMIT consecutive data grants taken while a
// fetch was waiting, the fetch is granted once.
module mem_arb_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iIReq,
    input  logic iDReq,
    input  logic iGrantStrobe,
    output logic oGrant
);

    logic [3:0] starveCount;

    // Combinational priority: fetch wins only when data is idle or fetch is starved
    always_comb begin
        oGrant = GNT_D;
        if (iIReq && (!iDReq || (starveCount == 4'(STARVE_LIMIT)))) begin
            oGrant = GNT_I;
        end
    end

    // Count data grants taken over a waiting fetch; any other grant clears it
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            starveCount <= '0;
        end else if (iGrantStrobe) begin
            if ((oGrant == GNT_D) && iIReq) begin
                starveCount <= starveCount + 4'd1;
            end else begin
                starveCount <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data
// requesters. Each access runs grant -> issue -> wait latency -> ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIReq,
    input  logic [31:0] iIAddress,
    output logic [31:0] oIReadData,
    output logic        oIAck,
    input  logic        iDReq,
    input  logic        iDWrite,
    input  logic [3:0]  iDByteEnable,
    input  logic [31:0] iDAddress,
    input  logic [31:0] iDWriteData,
    output logic [31:0] oDReadData,
    output logic        oDAck,
    output logic        oMReadEnable,
    output logic        oMWriteEnable,
    output logic [3:0]  oMByteEnable,
    output logic [31:0] oMAddress,
    output logic [31:0] oMWriteData,
    input  logic [31:0] iMReadData,
    output logic [1:0]  mArbState
);

    arbState_t  state;
    logic       grantQ;
    logic       accWrite;
    logic [2:0] latCount;
    logic       grantNow;
    logic       grantStrobe;

    // A grant is taken only from IDLE; requests in other states wait
    assign grantStrobe = (state == IDLE) && (iIReq || iDReq);
    assign mArbState   = state;

    mem_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) uSelect (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iIReq       (iIReq),
        .iDReq       (iDReq),
        .iGrantStrobe(grantStrobe),
        .oGrant      (grantNow)
    );

    // Access sequencer with registered memory strobes, read data and acks
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state         <= IDLE;
            grantQ        <= GNT_I;
            accWrite      <= 1'b0;
            latCount      <= '0;
            oIReadData    <= '0;
            oIAck         <= 1'b0;
            oDReadData    <= '0;
            oDAck         <= 1'b0;
            oMReadEnable  <= 1'b0;
            oMWriteEnable <= 1'b0;
            oMByteEnable  <= '0;
            oMAddress     <= '0;
            oMWriteData   <= '0;
        end else begin
            oIAck <= 1'b0;
            oDAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantStrobe) begin
                        grantQ <= grantNow;
                        if (grantNow == GNT_I) begin
                            oMAddress     <= iIAddress;
                            oMByteEnable  <= BE_ALL;
                            oMWriteData   <= '0;
                            accWrite      <= 1'b0;
                            oMReadEnable  <= 1'b1;
                            oMWriteEnable <= 1'b0;
                        end else begin
                            oMAddress     <= iDAddress;
                            oMByteEnable  <= iDByteEnable;
                            oMWriteData   <= iDWriteData;
                            accWrite      <= iDWrite;
                            oMReadEnable  <= !iDWrite;
                            oMWriteEnable <= iDWrite;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    oMReadEnable  <= 1'b0;
                    oMWriteEnable <= 1'b0;
                    latCount      <= 3'(MEM_LATENCY - 1);
                    state         <= WAIT;
                end
                WAIT: begin
                    if (latCount == '0) begin
                        if (grantQ == GNT_I) begin
                            oIReadData <= iMReadData;
                            oIAck      <= 1'b1;
                        end else begin
                            if (!accWrite) begin
                                oDReadData <= iMReadData;
                            end
                            oDAck <= 1'b1;
                        end
                        state <= ACK;
                    end else begin
                        latCount <= latCount - 3'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (latency 1 and latency 3 builds).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iReq;
    logic [31:0] iAddr;
    logic        dReq;
    logic        dWrite;
    logic [3:0]  dBe;
    logic [31:0] dAddr;
    logic [31:0] dWData;
    logic [31:0] mRData;

    logic [31:0] iRData, dRData, mAddr, mWData;
    logic        iAck, dAck, mRe, mWe;
    logic [3:0]  mBe;
    logic [1:0]  st;

    logic [31:0] l3IRData, l3DRData, l3MAddr, l3MWData;
    logic        l3IAck, l3DAck, l3MRe, l3MWe;
    logic [3:0]  l3MBe;
    logic [1:0]  l3St;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .iCLK(clk), .iRST(rst),
        .iIReq(iReq), .iIAddress(iAddr), .oIReadData(iRData), .oIAck(iAck),
        .iDReq(dReq), .iDWrite(dWrite), .iDByteEnable(dBe), .iDAddress(dAddr),
        .iDWriteData(dWData), .oDReadData(dRData), .oDAck(dAck),
        .oMReadEnable(mRe), .oMWriteEnable(mWe), .oMByteEnable(mBe),
        .oMAddress(mAddr), .oMWriteData(mWData), .iMReadData(mRData),
        .mArbState(st)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dutL3 (
        .iCLK(clk), .iRST(rst),
        .iIReq(iReq), .iIAddress(iAddr), .oIReadData(l3IRData), .oIAck(l3IAck),
        .iDReq(dReq), .iDWrite(dWrite), .iDByteEnable(dBe), .iDAddress(dAddr),
        .iDWriteData(dWData), .oDReadData(l3DRData), .oDAck(l3DAck),
        .oMReadEnable(l3MRe), .oMWriteEnable(l3MWe), .oMByteEnable(l3MBe),
        .oMAddress(l3MAddr), .oMWriteData(l3MWData), .iMReadData(mRData),
        .mArbState(l3St)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; iReq = 1'b0; iAddr = '0; dReq = 1'b0; dWrite = 1'b0;
        dBe = '0; dAddr = '0; dWData = '0; mRData = '0;
        tick(); tick();
        chk("rst_state", {30'd0, st}, 32'd0);
        chk("rst_ird", iRData, 32'd0);
        chk("rst_drd", dRData, 32'd0);
        chk("rst_strobes", {30'd0, mRe, mWe}, 32'd0);
        chk("rst_maddr", mAddr, 32'd0);
        chk("rst_acks", {30'd0, iAck, dAck}, 32'd0);
        rst = 1'b0;

        // Test 1: fetch only, latency 1
        iReq = 1'b1; iAddr = 32'h0040_0000; mRData = 32'h0000_0013;
        tick();
        chk("t1_state_issue", {30'd0, st}, 32'd1);
        chk("t1_re", {31'd0, mRe}, 32'd1);
        chk("t1_we", {31'd0, mWe}, 32'd0);
        chk("t1_addr", mAddr, 32'h0040_0000);
        chk("t1_be", {28'd0, mBe}, 32'hF);
        tick();
        chk("t1_state_wait", {30'd0, st}, 32'd2);
        chk("t1_re_wait", {31'd0, mRe}, 32'd0);
        chk("t1_noack_c2", {31'd0, iAck}, 32'd0);
        tick();
        chk("t1_iack", {31'd0, iAck}, 32'd1);
        chk("t1_ird", iRData, 32'h0000_0013);
        chk("t1_state_ack", {30'd0, st}, 32'd3);
        iReq = 1'b0;
        tick();
        chk("t1_iack_pulse", {31'd0, iAck}, 32'd0);
        chk("t1_idle", {30'd0, st}, 32'd0);

        // Test 2: simultaneous fetch and data read
        iReq = 1'b1; iAddr = 32'h0040_0004;
        dReq = 1'b1; dWrite = 1'b0; dBe = 4'hF; dAddr = 32'h1001_0000;
        mRData = 32'hCAFE_0001;
        tick();
        chk("t2_d_addr", mAddr, 32'h1001_0000);
        chk("t2_d_re", {31'd0, mRe}, 32'd1);
        tick();
        tick();
        chk("t2_dack", {31'd0, dAck}, 32'd1);
        chk("t2_no_iack_c3", {31'd0, iAck}, 32'd0);
        chk("t2_drd", dRData, 32'hCAFE_0001);
        dReq = 1'b0; mRData = 32'h0000_0093;
        tick();
        chk("t2_idle_c4", {30'd0, st}, 32'd0);
        tick();
        chk("t2_i_issue", {30'd0, st}, 32'd1);
        chk("t2_i_addr", mAddr, 32'h0040_0004);
        chk("t2_i_be", {28'd0, mBe}, 32'hF);
        tick();
        tick();
        chk("t2_iack", {31'd0, iAck}, 32'd1);
        chk("t2_ird", iRData, 32'h0000_0093);
        chk("t2_drd_kept", dRData, 32'hCAFE_0001);
        iReq = 1'b0;
        tick();

        // Test 3: starvation limit of 4 with both requesters held high
        iReq = 1'b1; iAddr = 32'h0040_0008;
        dReq = 1'b1; dWrite = 1'b0; dBe = 4'hF; dAddr = 32'h1001_0010;
        mRData = 32'h0000_0113;
        for (int c = 1; c <= 23; c++) begin
            tick();
            chk($sformatf("t3_dack_c%0d", c), {31'd0, dAck},
                {31'd0, ((c % 4) == 3) && (c != 19)});
            chk($sformatf("t3_iack_c%0d", c), {31'd0, iAck}, {31'd0, c == 19});
            if (c == 17) chk("t3_i_addr", mAddr, 32'h0040_0008);
            if (c == 21) chk("t3_d_after_i", mAddr, 32'h1001_0010);
            if (c == 19) iReq = 1'b0;
        end
        dReq = 1'b0;
        tick();
        chk("t3_idle", {30'd0, st}, 32'd0);

        // Test 4: data write, partial lane, read data untouched
        dReq = 1'b1; dWrite = 1'b1; dBe = 4'b0010; dAddr = 32'h1001_0001;
        dWData = 32'h0000_AB00; mRData = 32'hDEAD_BEEF;
        tick();
        chk("t4_we", {31'd0, mWe}, 32'd1);
        chk("t4_re", {31'd0, mRe}, 32'd0);
        chk("t4_addr", mAddr, 32'h1001_0001);
        chk("t4_be", {28'd0, mBe}, 32'h2);
        chk("t4_wdata", mWData, 32'h0000_AB00);
        tick();
        chk("t4_we_off", {31'd0, mWe}, 32'd0);
        chk("t4_re_off", {31'd0, mRe}, 32'd0);
        tick();
        chk("t4_dack", {31'd0, dAck}, 32'd1);
        chk("t4_drd_kept", dRData, 32'h0000_0113);
        dBe = 4'b0000;
        tick();
        // Zero byte mask write is still issued and acked
        tick();
        chk("t4z_we", {31'd0, mWe}, 32'd1);
        chk("t4z_be", {28'd0, mBe}, 32'h0);
        tick();
        tick();
        chk("t4z_dack", {31'd0, dAck}, 32'd1);
        chk("t4z_drd_kept", dRData, 32'h0000_0113);
        dReq = 1'b0; dWrite = 1'b0;
        tick();

        // Test 5: latency 3 build, data read
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dReq = 1'b1; dWrite = 1'b0; dBe = 4'hF; dAddr = 32'h1001_0020;
        mRData = 32'h1111_1111;
        tick();
        chk("t5_issue", {30'd0, l3St}, 32'd1);
        chk("t5_re", {31'd0, l3MRe}, 32'd1);
        tick();
        chk("t5_wait_c2", {30'd0, l3St}, 32'd2);
        tick();
        chk("t5_wait_c3", {30'd0, l3St}, 32'd2);
        chk("t5_noack_c3", {31'd0, l3DAck}, 32'd0);
        tick();
        chk("t5_wait_c4", {30'd0, l3St}, 32'd2);
        chk("t5_noack_c4", {31'd0, l3DAck}, 32'd0);
        mRData = 32'h4444_4444;
        tick();
        mRData = 32'h5555_5555;
        chk("t5_dack", {31'd0, l3DAck}, 32'd1);
        chk("t5_drd", l3DRData, 32'h4444_4444);
        dReq = 1'b0;
        tick();
        chk("t5_idle", {30'd0, l3St}, 32'd0);

        // Test 6: reset during WAIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dReq = 1'b1; dWrite = 1'b0; dAddr = 32'h1001_0030; mRData = 32'h6666_6666;
        tick();
        tick();
        chk("t6_in_wait", {30'd0, st}, 32'd2);
        rst = 1'b1;
        tick();
        chk("t6_state", {30'd0, st}, 32'd0);
        chk("t6_strobes", {30'd0, mRe, mWe}, 32'd0);
        chk("t6_acks", {30'd0, iAck, dAck}, 32'd0);
        rst = 1'b0; dReq = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("t6_noack_%0d", c), {30'd0, iAck, dAck}, 32'd0);
        end
        iReq = 1'b1; iAddr = 32'h0040_0010; mRData = 32'h0000_0077;
        tick();
        chk("t6_i_issue", {30'd0, st}, 32'd1);
        chk("t6_i_addr", mAddr, 32'h0040_0010);
        tick();
        tick();
        chk("t6_iack", {31'd0, iAck}, 32'd1);
        chk("t6_ird", iRData, 32'h0000_0077);
        iReq = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
